operand_b_sequencer: RTL
========================

// Module: operand_b_sequencer
// PURPOSE
//  Multi-cycle control FSM that drives the operand-B select (MUX_B) plus the memory/MDR/register-file
//  strobes for one decoded SPARC instruction at a time. Sits between the decode stage and the B-operand
//  mux: selects Register_B(00), Shifter_Extender_Result(01), MDR(10) or zero-extended CWP(11) per step.
//  Sequences ALU, RDPSR, branch/call, load and store flows with a MOC memory handshake.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max MEM_WAIT cycles before Mem_Error (used only with OPB_SEQ_TIMEOUT_EN)
//  TMR_W           5   timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  Clk          in   1  clock, all state on rising edge
//  Reset        in   1  synchronous, active-high reset
//  Start        in   1  new instruction valid; sampled only in IDLE
//  Op           in   2  instruction op field
//  Op3          in   6  instruction op3 field
//  I            in   1  immediate bit (1 = simm13 via shifter/extender)
//  MOC          in   1  memory operation complete, sampled in MEM_WAIT
//  MUX_B        out  2  operand-B select
//  MAR_Load     out  1  load memory address register
//  MEM_Request  out  1  memory access active
//  MEM_RW       out  1  1 = write (store), 0 = read
//  MDR_Load     out  1  capture read data into MDR
//  RF_Write     out  1  register-file write enable
//  Busy         out  1  high in every state except IDLE
//  Done         out  1  one-cycle completion pulse
//  Mem_Error    out  1  timeout flag, valid with Done
// BEHAVIOUR
//  States: IDLE, DECODE, EXEC, MEM_ADDR, MEM_WAIT, LOAD_WB, DONE. Outputs are Moore from registered state,
//  except MDR_Load (MEM_WAIT & load & MOC).
//  Reset: state=IDLE, Op/Op3/I latches=0, timer=0; all outputs 0, MUX_B=2'b00. Reset in any state -> IDLE on
//  the next edge; MEM_Request drops that cycle; no Done is emitted for the aborted instruction.
//  Classes (from latched fields): MEM = Op==3; STORE = MEM & Op3[2] & ~Op3[3]; LOAD = MEM & ~STORE;
//  RDPSR = Op==2 & Op3==6'h29; ALU = Op==2 & ~RDPSR; CTI = Op==0 or Op==1.
//  IDLE: MUX_B=00. Start=1 -> latch Op/Op3/I, go DECODE. Start while not IDLE is ignored (no queueing).
//  DECODE: 1 cycle, no strobes. MEM -> MEM_ADDR; otherwise -> EXEC.
//  EXEC: MUX_B = RDPSR ? 11 : (CTI | I) ? 01 : 00. RF_Write = ALU | RDPSR. -> DONE.
//  MEM_ADDR: MUX_B = I ? 01 : 00; MAR_Load=1. Clear timer. -> MEM_WAIT.
//  MEM_WAIT: MEM_Request=1; MEM_RW=STORE; MUX_B holds the MEM_ADDR value.
//   MOC=1: LOAD -> LOAD_WB with MDR_Load=1 in this cycle; STORE -> DONE.
//   MOC=0: stay in MEM_WAIT; timer increments (saturating at TIMEOUT_CYCLES).
//  LOAD_WB: MUX_B=10, RF_Write=1. -> DONE.
//  DONE: Done=1 for 1 cycle; Busy=1. -> IDLE. The earliest next Start is accepted in the following cycle.
//  Latency from the Start edge to Done high: ALU/RDPSR/CTI = 3 cycles; store = 3+W; load = 4+W,
//  where W = number of MEM_WAIT cycles (W>=1).
//  MOC outside MEM_WAIT is ignored. At most one RF_Write cycle per instruction.
// CONFIGURATION
//  OPB_SEQ_TIMEOUT_EN defined: in MEM_WAIT with MOC=0 and timer==TIMEOUT_CYCLES-1 -> DONE; Mem_Error=1
//   together with Done; no MDR_Load/RF_Write for that instruction. MOC=1 on the same cycle wins (normal path).
//  Not defined: no timer logic; MEM_WAIT waits indefinitely; Mem_Error is tied to 0.
// TESTING
//  Reset held 2 cycles mid-MEM_WAIT -> next cycle IDLE, MUX_B=00, all strobes 0, no Done.
//  ALU reg: Start, Op=2, Op3=6'h00, I=0 -> EXEC at +2 (MUX_B=00, RF_Write=1), Done at +3.
//  RDPSR: Op=2, Op3=6'h29 -> EXEC MUX_B=11, RF_Write=1; ALU imm (I=1) -> MUX_B=01.
//  Load: Op=3, Op3=6'h00, I=1, MOC high on the 3rd MEM_WAIT cycle -> MAR_Load with MUX_B=01;
//   MEM_RW=0 for 3 cycles; MDR_Load on the MOC cycle; LOAD_WB MUX_B=10, RF_Write=1; Done at +7.
//  Store: Op=3, Op3=6'h04, MOC on the 1st MEM_WAIT cycle -> MEM_RW=1, RF_Write never asserted, Done at +4.
//  With OPB_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16: load with MOC held 0 -> exactly 16 MEM_WAIT cycles, then Done=1
//   with Mem_Error=1, no RF_Write; a Start during Busy is ignored.

Source files
------------

// File: rtl/operand_b_sequencer_if.sv
// Operand-B sequencer bus: decode-side instruction fields, memory handshake,
// operand-B select and the memory/MDR/register-file strobes.
interface operand_b_sequencer_if;
  logic       Start;
  logic [1:0] Op;
  logic [5:0] Op3;
  logic       I;
  logic       MOC;
  logic [1:0] MUX_B;
  logic       MAR_Load;
  logic       MEM_Request;
  logic       MEM_RW;
  logic       MDR_Load;
  logic       RF_Write;
  logic       Busy;
  logic       Done;
  logic       Mem_Error;

  modport master (
    output Start, Op, Op3, I, MOC,
    input  MUX_B, MAR_Load, MEM_Request, MEM_RW, MDR_Load, RF_Write, Busy, Done, Mem_Error
  );

  modport slave (
    input  Start, Op, Op3, I, MOC,
    output MUX_B, MAR_Load, MEM_Request, MEM_RW, MDR_Load, RF_Write, Busy, Done, Mem_Error
  );
endinterface

// File: rtl/operand_b_sequencer.sv
// Multi-cycle operand-B select / memory-strobe sequencer for one SPARC instruction at a time.
// Optional MEM_WAIT timeout is enabled by defining OPB_SEQ_TIMEOUT_EN.
module operand_b_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMR_W          = 5
) (
  input logic                   Clk,
  input logic                   Reset,
  operand_b_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_EXEC     = 3'd2,
    ST_MEM_ADDR = 3'd3,
    ST_MEM_WAIT = 3'd4,
    ST_LOAD_WB  = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  if ((TIMEOUT_CYCLES < 32'sd1) || (TIMEOUT_CYCLES >= (32'sd1 <<< TMR_W))) begin : g_bad_cfg
    $error("operand_b_sequencer: TMR_W cannot hold TIMEOUT_CYCLES");
  end

  state_e     state_r, state_s;
  logic [1:0] op_r;
  logic [5:0] op3_r;
  logic       i_r;
  logic       tmo_s;
  logic       timeout_hit_s;

  logic [1:0] mux_b_s, mux_b_r;
  logic       mar_load_s, mar_load_r;
  logic       mem_request_s, mem_request_r;
  logic       mem_rw_s, mem_rw_r;
  logic       rf_write_s, rf_write_r;
  logic       busy_s, busy_r;
  logic       done_s, done_r;
  logic       mem_error_s, mem_error_r;

  // Instruction classes decoded from the latched fields
  logic is_mem_s, is_store_s, is_load_s, is_rdpsr_s, is_alu_s, is_cti_s;
  logic [1:0] addr_sel_s;
  assign is_mem_s   = (op_r == 2'd3);
  assign is_store_s = is_mem_s & op3_r[2] & ~op3_r[3];
  assign is_load_s  = is_mem_s & ~is_store_s;
  assign is_rdpsr_s = (op_r == 2'd2) & (op3_r == 6'h29);
  assign is_alu_s   = (op_r == 2'd2) & ~is_rdpsr_s;
  assign is_cti_s   = (op_r == 2'd0) | (op_r == 2'd1);
  assign addr_sel_s = i_r ? 2'b01 : 2'b00;

`ifdef OPB_SEQ_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TMO_MAX_C  = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMO_LAST_C = TMR_W'(TIMEOUT_CYCLES - 1);
  logic [TMR_W-1:0] timer_r;

  // MEM_WAIT cycle counter, cleared on address issue, saturating at the limit
  always_ff @(posedge Clk) begin
    if (Reset) begin
      timer_r <= '0;
    end else if (state_r == ST_MEM_ADDR) begin
      timer_r <= '0;
    end else if ((state_r == ST_MEM_WAIT) && !bus.MOC && (timer_r != TMO_MAX_C)) begin
      timer_r <= timer_r + TMR_W'(1'b1);
    end else begin
      timer_r <= timer_r;
    end
  end

  assign tmo_s = (timer_r == TMO_LAST_C);
`else
  assign tmo_s = 1'b0;
`endif

  // State register and instruction field latch
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      op_r    <= 2'd0;
      op3_r   <= 6'd0;
      i_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_IDLE) && bus.Start) begin
        op_r  <= bus.Op;
        op3_r <= bus.Op3;
        i_r   <= bus.I;
      end else begin
        op_r  <= op_r;
        op3_r <= op3_r;
        i_r   <= i_r;
      end
    end
  end

  // Next-state logic; MOC on the timeout cycle takes the normal path
  always_comb begin
    state_s       = state_r;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE:     state_s = bus.Start ? ST_DECODE : ST_IDLE;
      ST_DECODE:   state_s = is_mem_s ? ST_MEM_ADDR : ST_EXEC;
      ST_EXEC:     state_s = ST_DONE;
      ST_MEM_ADDR: state_s = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        if (bus.MOC) begin
          state_s = is_load_s ? ST_LOAD_WB : ST_DONE;
        end else if (tmo_s) begin
          state_s       = ST_DONE;
          timeout_hit_s = 1'b1;
        end else begin
          state_s = ST_MEM_WAIT;
        end
      end
      ST_LOAD_WB:  state_s = ST_DONE;
      ST_DONE:     state_s = ST_IDLE;
      default:     state_s = ST_IDLE;
    endcase
  end

  // Moore outputs of the upcoming state, so they can be registered
  always_comb begin
    mux_b_s       = 2'b00;
    mar_load_s    = 1'b0;
    mem_request_s = 1'b0;
    mem_rw_s      = 1'b0;
    rf_write_s    = 1'b0;
    done_s        = 1'b0;
    mem_error_s   = 1'b0;
    busy_s        = (state_s != ST_IDLE);
    case (state_s)
      ST_IDLE:   mux_b_s = 2'b00;
      ST_DECODE: mux_b_s = 2'b00;
      ST_EXEC: begin
        if (is_rdpsr_s) begin
          mux_b_s = 2'b11;
        end else if (is_cti_s | i_r) begin
          mux_b_s = 2'b01;
        end else begin
          mux_b_s = 2'b00;
        end
        rf_write_s = is_alu_s | is_rdpsr_s;
      end
      ST_MEM_ADDR: begin
        mux_b_s    = addr_sel_s;
        mar_load_s = 1'b1;
      end
      ST_MEM_WAIT: begin
        mux_b_s       = addr_sel_s;
        mem_request_s = 1'b1;
        mem_rw_s      = is_store_s;
      end
      ST_LOAD_WB: begin
        mux_b_s    = 2'b10;
        rf_write_s = 1'b1;
      end
      ST_DONE: begin
        done_s      = 1'b1;
        mem_error_s = timeout_hit_s;
      end
      default: mux_b_s = 2'b00;
    endcase
  end

  // Output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mux_b_r       <= 2'b00;
      mar_load_r    <= 1'b0;
      mem_request_r <= 1'b0;
      mem_rw_r      <= 1'b0;
      rf_write_r    <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      mem_error_r   <= 1'b0;
    end else begin
      mux_b_r       <= mux_b_s;
      mar_load_r    <= mar_load_s;
      mem_request_r <= mem_request_s;
      mem_rw_r      <= mem_rw_s;
      rf_write_r    <= rf_write_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      mem_error_r   <= mem_error_s;
    end
  end

  assign bus.MUX_B       = mux_b_r;
  assign bus.MAR_Load    = mar_load_r;
  assign bus.MEM_Request = mem_request_r;
  assign bus.MEM_RW      = mem_rw_r;
  assign bus.RF_Write    = rf_write_r;
  assign bus.Busy        = busy_r;
  assign bus.Done        = done_r;
  assign bus.Mem_Error   = mem_error_r;
  // Read data must be captured in the same cycle MOC is seen
  assign bus.MDR_Load    = (state_r == ST_MEM_WAIT) & is_load_s & bus.MOC;

endmodule
